// File: rtl/rng_pkg.sv
// rng_pkg: shared width helpers, mode encoding and von Neumann pair codes for rng_pool
package rng_pkg;

    // Bit counter holds 0..WIDTH-1
    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

    // Word count holds 0..DEPTH inclusive
    function automatic int FCNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Run counter saturates at the cutoff, so it must represent the cutoff itself
    function automatic int RUN_W(input int cutoff);
        return $clog2(cutoff + 1);
    endfunction

    typedef enum logic {
        MODE_RAW = 1'b0,
        MODE_VN  = 1'b1
    } mode_e;

    // Pair codes are {first, second}; only the unequal ones yield a bit
    localparam logic [1:0] VN_PAIR_00 = 2'b00;
    localparam logic [1:0] VN_PAIR_01 = 2'b01;
    localparam logic [1:0] VN_PAIR_10 = 2'b10;
    localparam logic [1:0] VN_PAIR_11 = 2'b11;

endpackage

// File: rtl/rng_fifo.sv
// rng_fifo: first-word-fall-through synchronous word pool
//   clk, reset_n : clock, async active-low reset
//   push, din    : write din at the tail (ignored when full unless popping)
//   pop          : drop the head word (ignored when empty)
//   flush        : empty the pool; overrides push and pop
//   head         : word at the read pointer (raw storage, caller gates validity)
//   count        : words held
module rng_fifo
    import rng_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            head,
    output logic [FCNT_W(DEPTH)-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = FCNT_W(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    count_q, count_d;
    logic             wr, rd;

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        rd       = pop && count_q != '0 && !flush;
        wr       = push && (count_q != FW'(DEPTH) || rd) && !flush;
        wr_ptr_d = flush ? '0 : wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = flush ? '0 : rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = flush ? '0 : (wr && !rd) ? count_q + 1'b1 : (rd && !wr) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is nonzero
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rng_pool.sv
// rng_pool: collects TRNG bits into words, optionally debiases, health-tests and pools them
//   clk, reset_n          : clock, async active-low reset
//   en                    : allow bit acceptance (draining continues regardless)
//   debias_en             : 1 = von Neumann pairs, 0 = raw bits
//   trng_bit/trng_valid   : raw entropy input, accepted when trng_next && trng_valid
//   trng_next             : ready for a raw bit
//   req                   : consumer ready; pops when req && output_valid
//   random_word           : head word, 0 while output_valid is low
//   output_valid          : head word present and health test clean
//   fifo_count            : words held
//   health_fail           : sticky repetition-count failure
//   clear_fail            : clears health_fail and the run counter
module rng_pool
    import rng_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int RCT_CUTOFF = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        debias_en,
    input  logic                        trng_bit,
    input  logic                        trng_valid,
    output logic                        trng_next,
    input  logic                        req,
    output logic [WIDTH-1:0]            random_word,
    output logic                        output_valid,
    output logic [FCNT_W(DEPTH)-1:0]    fifo_count,
    output logic                        health_fail,
    input  logic                        clear_fail
);
    localparam int CW = CNT_W(WIDTH);
    localparam int RW = RUN_W(RCT_CUTOFF);
    localparam int FW = FCNT_W(DEPTH);

    logic [CW-1:0]    bit_cnt_q, bit_cnt_d, cnt_base;
    logic [WIDTH-1:0] word_q, word_d, word_base, word_next, head;
    logic [RW-1:0]    run_q, run_d, run_step;
    logic             half_q, half_d, half_base;
    logic             half_bit_q, half_bit_d;
    logic             prev_q, prev_d;
    logic             health_fail_q, health_fail_d;
    mode_e            mode_q, mode_d;
    logic [1:0]       pair;
    logic             mode_chg, accept, trip, emit, emit_bit, done, push, pop;

    assign trng_next    = en && !health_fail_q && fifo_count != FW'(DEPTH);
    assign output_valid = fifo_count != '0 && !health_fail_q;
    assign random_word  = output_valid ? head : '0;
    assign health_fail  = health_fail_q;
    assign pop          = req && output_valid;

    always_comb begin
        mode_d        = debias_en ? MODE_VN : MODE_RAW;
        // A mode switch throws away the pending half-pair and partial word
        mode_chg      = mode_d != mode_q;
        accept        = trng_next && trng_valid;
        cnt_base      = mode_chg ? '0 : bit_cnt_q;
        word_base     = mode_chg ? '0 : word_q;
        half_base     = mode_chg ? 1'b0 : half_q;
        // Run length of the raw stream; a zero count means no previous bit to compare
        run_step      = (run_q == '0 || trng_bit != prev_q) ? RW'(1) :
                        (run_q == RW'(RCT_CUTOFF)) ? run_q : run_q + 1'b1;
        trip          = accept && run_step == RW'(RCT_CUTOFF);
        pair          = {half_bit_q, trng_bit};
        emit          = accept && (mode_d == MODE_RAW ||
                        (half_base && pair != VN_PAIR_00 && pair != VN_PAIR_11));
        emit_bit      = (mode_d == MODE_VN) ? half_bit_q : trng_bit;
        word_next     = {word_base[WIDTH-2:0], emit_bit};
        done          = emit && cnt_base == CW'(WIDTH - 1);
        // A tripping bit never lands in the pool
        push          = done && !trip;
        bit_cnt_d     = (trip || done) ? '0 : emit ? cnt_base + 1'b1 : cnt_base;
        word_d        = (trip || done) ? '0 : emit ? word_next : word_base;
        half_d        = trip ? 1'b0 : (accept && mode_d == MODE_VN) ? !half_base : half_base;
        half_bit_d    = accept ? trng_bit : half_bit_q;
        prev_d        = accept ? trng_bit : prev_q;
        // A new failure outranks a simultaneous clear
        run_d         = trip ? run_step : clear_fail ? '0 : accept ? run_step : run_q;
        health_fail_d = trip ? 1'b1 : clear_fail ? 1'b0 : health_fail_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q     <= '0;
            word_q        <= '0;
            run_q         <= '0;
            half_q        <= 1'b0;
            half_bit_q    <= 1'b0;
            prev_q        <= 1'b0;
            health_fail_q <= 1'b0;
            mode_q        <= MODE_RAW;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            word_q        <= word_d;
            run_q         <= run_d;
            half_q        <= half_d;
            half_bit_q    <= half_bit_d;
            prev_q        <= prev_d;
            health_fail_q <= health_fail_d;
            mode_q        <= mode_d;
        end
    end

    rng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (trip),
        .din     (word_next),
        .head    (head),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_rng_pool.sv
// tb_rng_pool: scoreboard bench for rng_pool (WIDTH=8, DEPTH=4, RCT_CUTOFF=16)
module tb_rng_pool;
    localparam int RCT = 16;

    logic       clk = 1'b0;
    logic       reset_n, en, debias_en, trng_bit, trng_valid, req, clear_fail;
    logic       trng_next, output_valid, health_fail;
    logic [7:0] random_word;
    logic [2:0] fifo_count;

    int         n_vec = 0;
    int         n_err = 0;

    logic [7:0] sb [$];
    logic [7:0] mdl_word;
    int         mdl_cnt, mdl_run;
    bit         mdl_half, mdl_hb, mdl_prev, mdl_deb;

    always #5 clk = ~clk;

    rng_pool #(
        .WIDTH      (8),
        .DEPTH      (4),
        .RCT_CUTOFF (RCT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .debias_en    (debias_en),
        .trng_bit     (trng_bit),
        .trng_valid   (trng_valid),
        .trng_next    (trng_next),
        .req          (req),
        .random_word  (random_word),
        .output_valid (output_valid),
        .fifo_count   (fifo_count),
        .health_fail  (health_fail),
        .clear_fail   (clear_fail)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_clear_partial();
        mdl_word = '0;
        mdl_cnt  = 0;
        mdl_half = 1'b0;
    endtask

    // Reference behaviour for one accepted raw bit
    task automatic mdl_accept(input bit b);
        bit e;
        mdl_run  = (mdl_run == 0 || b != mdl_prev) ? 1 : (mdl_run < RCT ? mdl_run + 1 : mdl_run);
        mdl_prev = b;
        if (mdl_run == RCT) begin
            sb.delete();
            mdl_clear_partial();
            return;
        end
        if (mdl_deb) begin
            if (!mdl_half) begin
                mdl_half = 1'b1;
                mdl_hb   = b;
                return;
            end
            mdl_half = 1'b0;
            if (mdl_hb == b) return;
            e = mdl_hb;
        end else begin
            e = b;
        end
        mdl_word = {mdl_word[6:0], e};
        mdl_cnt++;
        if (mdl_cnt == 8) begin
            sb.push_back(mdl_word);
            mdl_clear_partial();
        end
    endtask

    task automatic send_bit(input bit b);
        int n = 0;
        trng_bit   = b;
        trng_valid = 1'b1;
        while (!trng_next && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!trng_next) begin
            check("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            mdl_accept(b);
        end
        trng_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic set_mode(input bit m);
        if (m != mdl_deb) mdl_clear_partial();
        mdl_deb   = m;
        debias_en = m;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_fail = 1'b1;
        @(posedge clk);
        #1;
        clear_fail = 1'b0;
        mdl_run    = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        req = 1'b1;
        while (output_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        req = 1'b0;
        check({tag, "_drained"}, output_valid, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    // Every pop is compared against the oldest expected word
    always @(negedge clk) begin
        if (reset_n && req && output_valid) begin
            if (sb.size() == 0) check("pop_unexpected", random_word, 0);
            else check("pop_word", random_word, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t5 = 8'h5A;
        reset_n = 1'b0; en = 1'b0; debias_en = 1'b0; trng_bit = 1'b0;
        trng_valid = 1'b0; req = 1'b0; clear_fail = 1'b0;
        mdl_deb = 1'b0; mdl_run = 0; mdl_prev = 1'b0; mdl_hb = 1'b0;
        mdl_clear_partial();
        repeat (2) @(posedge clk);
        #1;
        check("rst_next", trng_next, 0);
        check("rst_valid", output_valid, 0);
        check("rst_word", random_word, 0);
        check("rst_count", fifo_count, 0);
        check("rst_fail", health_fail, 0);
        reset_n = 1'b1;
        en      = 1'b1;
        @(posedge clk);
        #1;

        // Raw word assembly, MSB first
        send_byte(8'hB2);
        check("t1_valid", output_valid, 1);
        check("t1_word", random_word, 8'hB2);
        check("t1_count", fifo_count, 1);

        // Fill to full, then a single pop
        repeat (3) send_byte(8'h55);
        check("t2_count_full", fifo_count, 4);
        check("t2_next_full", trng_next, 0);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("t2_head", random_word, 8'h55);
        check("t2_count", fifo_count, 3);
        check("t2_next", trng_next, 1);
        drain("t2");

        // Debias: a stray half-pair is dropped by toggling the mode
        set_mode(1'b1);
        send_bit(1'b1);
        set_mode(1'b0);
        set_mode(1'b1);
        repeat (4) send_byte(8'h87);
        check("t3_count", fifo_count, 1);
        check("t3_word", random_word, 8'hAA);
        drain("t3");

        // Repetition-count failure and recovery
        set_mode(1'b0);
        pulse_clear();
        repeat (8) send_bit(1'b1);
        check("t4_count8", fifo_count, 1);
        check("t4_word8", random_word, 8'hFF);
        repeat (8) send_bit(1'b1);
        check("t4_fail", health_fail, 1);
        check("t4_count_flush", fifo_count, 0);
        check("t4_valid_fail", output_valid, 0);
        check("t4_next_fail", trng_next, 0);
        pulse_clear();
        check("t4_cleared", health_fail, 0);
        repeat (15) send_bit(1'b1);
        send_bit(1'b0);
        check("t4_no_fail", health_fail, 0);
        check("t4_next", trng_next, 1);
        check("t4_count2", fifo_count, 2);
        drain("t4");

        // Simultaneous push and pop keep the count and the order
        send_byte(8'h3C);
        send_byte(8'hC3);
        for (int i = 7; i >= 1; i--) send_bit(t5[i]);
        trng_bit   = t5[0];
        trng_valid = 1'b1;
        req        = 1'b1;
        check("t5_next", trng_next, 1);
        @(posedge clk);
        #1;
        trng_valid = 1'b0;
        req        = 1'b0;
        mdl_accept(t5[0]);
        check("t5_count", fifo_count, 2);
        drain("t5");

        // Asynchronous reset mid-word
        send_byte(8'h96);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_valid", output_valid, 0);
        check("t6_word", random_word, 0);
        check("t6_count", fifo_count, 0);
        sb.delete();
        mdl_clear_partial();
        mdl_run = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("t6_valid7", output_valid, 0);
        send_bit(1'b1);
        check("t6_valid8", output_valid, 1);
        check("t6_word8", random_word, 8'h69);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
